// File: rtl/frame_scheduler.sv
// Per-frame sequencer around draw_blocks: clears the back buffer, launches a draw, waits for
// completion, then flips front/back on the next frame_start. Owns the framebuffer write port.
module frame_scheduler #(
  parameter int unsigned                 DRAW_WIDTH     = 640,
  parameter int unsigned                 DRAW_HEIGHT    = 480,
  parameter int unsigned                 DRAW_SIZE      = DRAW_WIDTH * DRAW_HEIGHT,
  parameter int unsigned                 DRAW_ADDRW     = $clog2(DRAW_SIZE),
  parameter int unsigned                 DRAW_DATAW     = 1,
  parameter logic [DRAW_DATAW-1:0]       CLEAR_VALUE    = '0,
  parameter int unsigned                 TIMEOUT_CYCLES = 4194304
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_start,
  output logic                  draw_start,
  input  logic                  draw_done,
  input  logic [DRAW_ADDRW-1:0] blk_addr,
  input  logic [DRAW_DATAW-1:0] blk_data,
  input  logic                  blk_we,
  output logic [DRAW_ADDRW-1:0] fb_addr_write,
  output logic [DRAW_DATAW-1:0] fb_data_in,
  output logic                  fb_we,
  output logic                  buf_sel,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  overrun,
  output logic                  timeout,
  input  logic                  clear_sticky
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DRAW_ADDRW-1:0] LAST_ADDR = DRAW_ADDRW'(DRAW_SIZE - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DRAW  = 2'd2,
    S_PEND  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DRAW_ADDRW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    buf_sel_q, buf_sel_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic                    draw_start_q, draw_start_d;
  logic                    fb_we_q, fb_we_d;
  logic [DRAW_ADDRW-1:0]   fb_addr_q, fb_addr_d;
  logic [DRAW_DATAW-1:0]   fb_data_q, fb_data_d;
  logic                    overrun_q, overrun_d;
  logic                    timeout_q, timeout_d;
  logic                    overrun_set;
  logic                    timeout_set;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    buf_sel_d     = buf_sel_q;
    frame_count_d = frame_count_q;
    draw_start_d  = 1'b0;
    fb_we_d       = 1'b0;
    fb_addr_d     = '0;
    fb_data_d     = '0;
    overrun_set   = 1'b0;
    timeout_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start && enable) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end

      S_CLEAR: begin
        fb_we_d   = 1'b1;
        fb_addr_d = clr_cnt_q;
        fb_data_d = CLEAR_VALUE;
        if (frame_start) overrun_set = 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d      = S_DRAW;
          draw_start_d = 1'b1;
          tmo_cnt_d    = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      S_DRAW: begin
        if (blk_we) begin
          fb_we_d   = 1'b1;
          fb_addr_d = blk_addr;
          fb_data_d = blk_data;
        end
        if (frame_start) overrun_set = 1'b1;
        // draw_done takes priority over a coincident terminal count
        if (draw_done) begin
          state_d = S_PEND;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      S_PEND: begin
        if (frame_start) begin
          buf_sel_d     = ~buf_sel_q;
          frame_count_d = frame_count_q + 16'd1;
          if (enable) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    overrun_d = overrun_set | (overrun_q & ~clear_sticky);
    timeout_d = timeout_set | (timeout_q & ~clear_sticky);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      clr_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      buf_sel_q     <= 1'b0;
      frame_count_q <= '0;
      draw_start_q  <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      buf_sel_q     <= buf_sel_d;
      frame_count_q <= frame_count_d;
      draw_start_q  <= draw_start_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  assign draw_start    = draw_start_q;
  assign fb_we         = fb_we_q;
  assign fb_addr_write = fb_addr_q;
  assign fb_data_in    = fb_data_q;
  assign buf_sel       = buf_sel_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_count   = frame_count_q;
  assign overrun       = overrun_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler on a small 8x4 framebuffer with a 100-cycle draw timeout.
module tb_frame_scheduler;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          frame_start;
  logic          draw_start;
  logic          draw_done;
  logic [AW-1:0] blk_addr;
  logic [DW-1:0] blk_data;
  logic          blk_we;
  logic [AW-1:0] fb_addr_write;
  logic [DW-1:0] fb_data_in;
  logic          fb_we;
  logic          buf_sel;
  logic          busy;
  logic [15:0]   frame_count;
  logic          overrun;
  logic          timeout;
  logic          clear_sticky;

  int checks = 0;
  int errors = 0;

  frame_scheduler #(
    .DRAW_WIDTH     (8),
    .DRAW_HEIGHT    (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .frame_start   (frame_start),
    .draw_start    (draw_start),
    .draw_done     (draw_done),
    .blk_addr      (blk_addr),
    .blk_data      (blk_data),
    .blk_we        (blk_we),
    .fb_addr_write (fb_addr_write),
    .fb_data_in    (fb_data_in),
    .fb_we         (fb_we),
    .buf_sel       (buf_sel),
    .busy          (busy),
    .frame_count   (frame_count),
    .overrun       (overrun),
    .timeout       (timeout),
    .clear_sticky  (clear_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // From the cycle the FSM enters CLEAR: 32 clear edges, the last one enters DRAW
  task automatic clear_to_draw();
    for (int k = 0; k < 32; k++) tick();
    chk("c2d_draw_start", {31'd0, draw_start}, 32'd1);
    chk("c2d_last_addr", {27'd0, fb_addr_write}, 32'd31);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame_start = 1'b0; draw_done = 1'b0;
    blk_addr = '0; blk_data = '0; blk_we = 1'b0; clear_sticky = 1'b0;
    #2;
    chk("rst_fb_we", {31'd0, fb_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_buf_sel", {31'd0, buf_sel}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_draw_start", {31'd0, draw_start}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: full clear sweep then one draw_start
    enable = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_no_early_we", {31'd0, fb_we}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("t1_clr_we", {31'd0, fb_we}, 32'd1);
      chk("t1_clr_addr", {27'd0, fb_addr_write}, i);
      chk("t1_clr_data", {31'd0, fb_data_in}, 32'd0);
      chk("t1_draw_start", {31'd0, draw_start}, (i == 31) ? 32'd1 : 32'd0);
    end

    // 2: forwarded write, done, swap
    blk_we = 1'b1; blk_addr = 5'd5; blk_data = 1'b1;
    tick();
    chk("t2_draw_start_once", {31'd0, draw_start}, 32'd0);
    chk("t2_fwd_we", {31'd0, fb_we}, 32'd1);
    chk("t2_fwd_addr", {27'd0, fb_addr_write}, 32'd5);
    chk("t2_fwd_data", {31'd0, fb_data_in}, 32'd1);
    blk_we = 1'b0; draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    chk("t2_pend_busy", {31'd0, busy}, 32'd1);
    chk("t2_pend_we", {31'd0, fb_we}, 32'd0);
    blk_we = 1'b1; blk_addr = 5'd7;
    tick();
    blk_we = 1'b0;
    chk("t2_pend_drop_we", {31'd0, fb_we}, 32'd0);
    chk("t2_no_swap_yet", {31'd0, buf_sel}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t2_buf_sel", {31'd0, buf_sel}, 32'd1);
    chk("t2_frame_count", {16'd0, frame_count}, 32'd1);
    chk("t2_no_overrun", {31'd0, overrun}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);

    // 3: frame_start during clear raises overrun only
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 10) frame_start = 1'b0;
      chk("t3_clr_we", {31'd0, fb_we}, 32'd1);
      chk("t3_clr_addr", {27'd0, fb_addr_write}, i);
      chk("t3_overrun", {31'd0, overrun}, (i >= 10) ? 32'd1 : 32'd0);
      if (i == 9) frame_start = 1'b1;
    end
    chk("t3_draw_start", {31'd0, draw_start}, 32'd1);
    chk("t3_buf_sel", {31'd0, buf_sel}, 32'd1);
    chk("t3_frame_count", {16'd0, frame_count}, 32'd1);
    clear_sticky = 1'b1;
    tick();
    chk("t3_sticky_clr", {31'd0, overrun}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t3_set_wins", {31'd0, overrun}, 32'd1);
    tick();
    clear_sticky = 1'b0;
    chk("t3_sticky_clr2", {31'd0, overrun}, 32'd0);

    // 4: timeout after 100 DRAW cycles (3 already spent above)
    for (int n = 4; n < 100; n++) tick();
    chk("t4_still_busy", {31'd0, busy}, 32'd1);
    chk("t4_no_timeout_yet", {31'd0, timeout}, 32'd0);
    tick();
    chk("t4_timeout", {31'd0, timeout}, 32'd1);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    chk("t4_buf_sel", {31'd0, buf_sel}, 32'd1);
    chk("t4_frame_count", {16'd0, frame_count}, 32'd1);
    chk("t4_fb_we", {31'd0, fb_we}, 32'd0);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    chk("t4_timeout_clr", {31'd0, timeout}, 32'd0);

    // 6: enable drops mid-frame; draw_done coincides with terminal count
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    clear_to_draw();
    enable = 1'b0;
    for (int n = 0; n < 99; n++) tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    chk("t6_done_wins_busy", {31'd0, busy}, 32'd1);
    chk("t6_done_wins_tmo", {31'd0, timeout}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t6_buf_sel", {31'd0, buf_sel}, 32'd0);
    chk("t6_frame_count", {16'd0, frame_count}, 32'd2);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t6_ignored_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t6_ignored_we", {31'd0, fb_we}, 32'd0);
    chk("t6_ignored_busy2", {31'd0, busy}, 32'd0);

    // 5: reset mid-DRAW with buf_sel and frame_count non-zero
    enable = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    clear_to_draw();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t5_pre_buf_sel", {31'd0, buf_sel}, 32'd1);
    chk("t5_pre_frame_count", {16'd0, frame_count}, 32'd3);
    clear_to_draw();
    blk_we = 1'b1; blk_addr = 5'd3; blk_data = 1'b1;
    tick();
    chk("t5_pre_fb_we", {31'd0, fb_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_fb_we", {31'd0, fb_we}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_buf_sel", {31'd0, buf_sel}, 32'd0);
    chk("t5_rst_frame_count", {16'd0, frame_count}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("t5_post_fb_we", {31'd0, fb_we}, 32'd0);
    chk("t5_post_busy", {31'd0, busy}, 32'd0);
    blk_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
